// File: rtl/isa_bus_pkg.sv
// rtl/isa_bus_pkg.sv - shared types, pin constants and sizing helper for the ISA I/O cycle engine
package isa_bus_pkg;

  // Bus-cycle phases; one complete ISA I/O cycle walks SETUP..RESP once.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_STROBE   = 3'd2,
    ST_WAIT_RDY = 3'd3,
    ST_HOLD     = 3'd4,
    ST_RESP     = 3'd5
  } isa_state_e;

  // AEN high tells slot cards not to decode the address lines.
  localparam logic ISA_IDLE_AEN   = 1'b1;
  // IOR#/IOW# are active low, so the released level is 1.
  localparam logic ISA_STROBE_OFF = 1'b1;

  // Width of one shared down-counter able to hold the largest phase length.
  function automatic int isa_cnt_width(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/isa_cycle_timer.sv
// rtl/isa_cycle_timer.sv - loadable saturating down-counter with done flag
module isa_cycle_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Load wins; otherwise count down and stick at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/isa_io_cycle_engine.sv
// rtl/isa_io_cycle_engine.sv - request/response ISA I/O read/write cycle generator
module isa_io_cycle_engine
  import isa_bus_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 15,
  parameter int HOLD_CYC    = 1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              sys_clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_byte,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] isa_addr,
  output logic [DATA_W-1:0] isa_data_out,
  output logic              isa_data_oe,
  input  logic [DATA_W-1:0] isa_data_in,
  input  logic              isa_iochrdy,
  output logic              isa_ior_n,
  output logic              isa_iow_n,
  output logic              isa_aen
);

  localparam int CNT_W = isa_cnt_width(SETUP_CYC, STROBE_CYC, HOLD_CYC, TIMEOUT_CYC);
  localparam logic [DATA_W-1:0] BYTE_MASK = DATA_W'(8'hFF);

  isa_state_e        state_q, state_d;
  logic              init_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              write_q;
  logic              byte_q;
  logic              tmo_q;
  logic [DATA_W-1:0] cap_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_timeout_q;

  logic              accept;
  logic              capture;
  logic              tmo_set;
  logic              tmr_load;
  logic [CNT_W-1:0]  tmr_val;
  logic              tmr_done;
  logic              byte_eff;
  logic              strobe_on;
  logic              bus_owned;

  // An 8-bit bus can only ever do byte transfers.
  assign byte_eff = (DATA_W == 8) ? 1'b1 : req_byte;

  isa_cycle_timer #(.W(CNT_W)) u_timer (
    .clk_i      (sys_clock),
    .rst_i      (reset),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Next-state logic; the timer is reloaded whenever the phase changes.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    tmo_set  = 1'b0;
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state_q)
      ST_IDLE: begin
        if (init_q && req_valid) begin
          accept  = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_done) state_d = ST_STROBE;
      end
      ST_STROBE: begin
        if (tmr_done) state_d = isa_iochrdy ? ST_HOLD : ST_WAIT_RDY;
      end
      ST_WAIT_RDY: begin
        if (isa_iochrdy) begin
          state_d = ST_HOLD;
        end else if (tmr_done) begin
          state_d = ST_HOLD;
          tmo_set = 1'b1;
        end
      end
      ST_HOLD: begin
        if (tmr_done) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (state_d != state_q) begin
      tmr_load = 1'b1;
      case (state_d)
        ST_SETUP:    tmr_val = CNT_W'(SETUP_CYC - 1);
        ST_STROBE:   tmr_val = CNT_W'(STROBE_CYC - 1);
        ST_WAIT_RDY: tmr_val = CNT_W'(TIMEOUT_CYC - 1);
        ST_HOLD:     tmr_val = CNT_W'(HOLD_CYC - 1);
        default:     tmr_val = '0;
      endcase
    end
  end

  // Read data is taken on the edge that ends the last strobe-low clock.
  assign capture = ((state_q == ST_STROBE) || (state_q == ST_WAIT_RDY)) && (state_d == ST_HOLD);

  // Phase register plus the post-reset ready qualifier.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      init_q  <= 1'b1;
    end
  end

  // Request capture, read-data capture and response registers.
  always_ff @(posedge sys_clock or posedge reset) begin
    if (reset) begin
      addr_q        <= '0;
      wdata_q       <= '0;
      write_q       <= 1'b0;
      byte_q        <= 1'b0;
      tmo_q         <= 1'b0;
      cap_q         <= '0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= req_addr;
        wdata_q <= byte_eff ? (req_wdata & BYTE_MASK) : req_wdata;
        write_q <= req_write;
        byte_q  <= byte_eff;
        tmo_q   <= 1'b0;
      end
      if (tmo_set) tmo_q <= 1'b1;
      if (capture) cap_q <= byte_q ? (isa_data_in & BYTE_MASK) : isa_data_in;
      if ((state_q == ST_HOLD) && (state_d == ST_RESP)) begin
        rsp_rdata_q   <= write_q ? '0 : cap_q;
        rsp_timeout_q <= tmo_q;
      end
    end
  end

  // Pin decode straight from the phase register so reset releases the bus at once.
  always_comb begin
    strobe_on = (state_q == ST_STROBE) || (state_q == ST_WAIT_RDY);
    bus_owned = (state_q == ST_SETUP) || strobe_on || (state_q == ST_HOLD);
  end

  assign req_ready    = init_q && (state_q == ST_IDLE);
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_rdata    = rsp_rdata_q;
  assign rsp_timeout  = rsp_timeout_q;
  assign isa_addr     = addr_q;
  assign isa_data_out = wdata_q;
  assign isa_data_oe  = write_q && bus_owned;
  assign isa_ior_n    = (strobe_on && !write_q) ? ~ISA_STROBE_OFF : ISA_STROBE_OFF;
  assign isa_iow_n    = (strobe_on &&  write_q) ? ~ISA_STROBE_OFF : ISA_STROBE_OFF;
  assign isa_aen      = bus_owned ? ~ISA_IDLE_AEN : ISA_IDLE_AEN;

endmodule

// File: tb/tb_isa_io_cycle_engine.sv
// tb/tb_isa_io_cycle_engine.sv - directed self-checking bench for isa_io_cycle_engine
module tb_isa_io_cycle_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_write, req_byte;
  logic [15:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic [15:0] isa_addr, isa_data_out, isa_data_in;
  logic        isa_data_oe, isa_iochrdy, isa_ior_n, isa_iow_n, isa_aen;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  int t_aen, t_strb, t_rsp, n_ior, n_iow, n_oe;
  bit both_low, data_bad, addr_bad;
  logic [15:0] obs_rdata;
  logic        obs_tmo;

  always #5 clk = ~clk;

  isa_io_cycle_engine dut (
    .sys_clock    (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_byte     (req_byte),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_timeout  (rsp_timeout),
    .isa_addr     (isa_addr),
    .isa_data_out (isa_data_out),
    .isa_data_oe  (isa_data_oe),
    .isa_data_in  (isa_data_in),
    .isa_iochrdy  (isa_iochrdy),
    .isa_ior_n    (isa_ior_n),
    .isa_iow_n    (isa_iow_n),
    .isa_aen      (isa_aen)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issue one request (called just after a negedge while idle) and profile the cycle.
  task automatic run_req(input logic wr, input logic byt, input logic [15:0] addr,
                         input logic [15:0] wd, input logic [15:0] exp_wd,
                         input logic [15:0] din, input int rdy_hi_at, input bit vary);
    req_valid   = 1'b1;
    req_write   = wr;
    req_byte    = byt;
    req_addr    = addr;
    req_wdata   = wd;
    isa_data_in = din;
    isa_iochrdy = (rdy_hi_at <= 0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 16'hFFFF;
    req_wdata = 16'hFFFF;
    req_write = ~wr;
    t_aen = -1; t_strb = -1; t_rsp = -1;
    n_ior = 0; n_iow = 0; n_oe = 0;
    both_low = 0; data_bad = 0; addr_bad = 0;
    obs_rdata = 'x; obs_tmo = 'x;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!isa_aen && t_aen < 0) t_aen = i;
      if ((!isa_ior_n || !isa_iow_n) && t_strb < 0) t_strb = i;
      if (!isa_ior_n) n_ior++;
      if (!isa_iow_n) n_iow++;
      if (!isa_ior_n && !isa_iow_n) both_low = 1;
      if (isa_data_oe) begin
        n_oe++;
        if (isa_data_out !== exp_wd) data_bad = 1;
      end
      if (!isa_aen && isa_addr !== addr) addr_bad = 1;
      if (rsp_valid) begin
        t_rsp     = i;
        obs_rdata = rsp_rdata;
        obs_tmo   = rsp_timeout;
        break;
      end
      if (vary) isa_data_in = din + 16'(i);
      if (rdy_hi_at > 0 && i >= rdy_hi_at) isa_iochrdy = 1'b1;
    end
    isa_iochrdy = 1'b1;
  endtask

  int t_fall1, t_fall2, n_rdy_hi, n_rsp;
  bit prev_aen, saw_rsp;

  initial begin
    reset = 1'b1; req_valid = 0; req_write = 0; req_byte = 0;
    req_addr = 0; req_wdata = 0; isa_data_in = 0; isa_iochrdy = 1;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_ior", isa_ior_n, 1);
    chk("rst_iow", isa_iow_n, 1);
    chk("rst_aen", isa_aen, 1);
    chk("rst_oe", isa_data_oe, 0);
    chk("rst_addr", isa_addr, 0);
    chk("rst_dout", isa_data_out, 0);
    chk("rst_rsp", {rsp_valid, rsp_timeout, rsp_rdata}, 0);
    reset = 1'b0;
    #1 chk("ready_before_edge", req_ready, 0);
    @(negedge clk);
    chk("ready_after_edge", req_ready, 1);

    // 16-bit write
    run_req(1, 0, 16'h0220, 16'hA55A, 16'hA55A, 16'h0000, 0, 0);
    chk("wr_aen_idx", t_aen, 0);
    chk("wr_strb_idx", t_strb, 1);
    chk("wr_iow_len", n_iow, 15);
    chk("wr_ior_len", n_ior, 0);
    chk("wr_oe_len", n_oe, 17);
    chk("wr_data", data_bad, 0);
    chk("wr_addr", addr_bad, 0);
    chk("wr_rsp_idx", t_rsp, 17);
    chk("wr_tmo", obs_tmo, 0);
    chk("wr_rdata", obs_rdata, 16'h0000);
    @(negedge clk);
    chk("wr_rsp_pulse", rsp_valid, 0);
    chk("wr_ready", req_ready, 1);

    // Byte read with zero extension
    run_req(0, 1, 16'h0388, 16'h0000, 16'h0000, 16'h12F7, 0, 0);
    chk("br_ior_len", n_ior, 15);
    chk("br_iow_len", n_iow, 0);
    chk("br_oe_len", n_oe, 0);
    chk("br_addr", addr_bad, 0);
    chk("br_rsp_idx", t_rsp, 17);
    chk("br_rdata", obs_rdata, 16'h00F7);
    @(negedge clk);

    // Byte write drives upper byte as zero
    run_req(1, 1, 16'h0279, 16'h1234, 16'h0034, 16'h0000, 0, 0);
    chk("bw_iow_len", n_iow, 15);
    chk("bw_data", data_bad, 0);
    chk("bw_oe_len", n_oe, 17);
    @(negedge clk);

    // Wait states: 7 extra low clocks, data taken on the last low clock
    run_req(0, 0, 16'h0300, 16'h0000, 16'h0000, 16'h3000, 22, 1);
    chk("ws_ior_len", n_ior, 22);
    chk("ws_rsp_idx", t_rsp, 24);
    chk("ws_rdata", obs_rdata, 16'h3016);
    chk("ws_tmo", obs_tmo, 0);
    chk("ws_both_low", both_low, 0);
    @(negedge clk);

    // IOCHRDY timeout
    run_req(0, 0, 16'h0301, 16'h0000, 16'h0000, 16'hBEEF, 100000, 0);
    chk("to_ior_len", n_ior, 270);
    chk("to_rsp_idx", t_rsp, 272);
    chk("to_tmo", obs_tmo, 1);
    chk("to_rdata", obs_rdata, 16'hBEEF);
    @(negedge clk);
    chk("to_ready", req_ready, 1);
    chk("to_rdata_hold", rsp_rdata, 16'hBEEF);
    chk("to_tmo_hold", rsp_timeout, 1);

    // Reset in the middle of a write strobe
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 16'h0100; req_wdata = 16'h5555;
    @(posedge clk);
    #1 req_valid = 0;
    repeat (6) @(negedge clk);
    chk("ar_iow_low", isa_iow_n, 0);
    chk("ar_oe_on", isa_data_oe, 1);
    #1 reset = 1'b1;
    #1;
    chk("ar_iow", isa_iow_n, 1);
    chk("ar_ior", isa_ior_n, 1);
    chk("ar_oe", isa_data_oe, 0);
    chk("ar_aen", isa_aen, 1);
    saw_rsp = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
    end
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) saw_rsp = 1;
    end
    chk("ar_no_rsp", saw_rsp, 0);
    chk("ar_ready", req_ready, 1);
    run_req(1, 0, 16'h0104, 16'h0F0F, 16'h0F0F, 16'h0000, 0, 0);
    chk("ar_next_iow", n_iow, 15);
    chk("ar_next_rsp", t_rsp, 17);
    chk("ar_next_data", data_bad, 0);
    @(negedge clk);

    // Back-to-back with req_valid held high
    req_valid = 1; req_write = 1; req_byte = 0; req_addr = 16'h0200; req_wdata = 16'h1111;
    @(posedge clk);
    t_fall1 = -1; t_fall2 = -1; n_rdy_hi = 0; n_rsp = 0; prev_aen = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (prev_aen && !isa_aen) begin
        if (t_fall1 < 0) t_fall1 = i;
        else if (t_fall2 < 0) t_fall2 = i;
      end
      prev_aen = isa_aen;
      if (i <= 17 && req_ready) n_rdy_hi++;
      if (rsp_valid) n_rsp++;
      if (i == 20) req_valid = 0;
    end
    chk("b2b_first", t_fall1, 0);
    chk("b2b_period", t_fall2 - t_fall1, 19);
    chk("b2b_ready_low", n_rdy_hi, 0);
    chk("b2b_rsp_cnt", n_rsp, 2);
    chk("b2b_idle", req_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/isa_io_cycle_engine.md
Name: isa_io_cycle_engine

Overview:
Parametrised ISA I/O bus-cycle generator for the riser. It replaces the fixed single-direction data_dir/IOR/IOW scheme with a request/response engine. Each accepted request runs one complete, correctly timed 8- or 16-bit I/O read or write on the card slot, with programmable setup/strobe/hold and IOCHRDY wait-state extension with timeout. It sits between the top-level state machine and the D/A/IOR/IOW/AEN pins.

Parameters:
DATA_W, 16, ISA data bus width; legal values 8 or 16.
ADDR_W, 16, ISA I/O address width driven on A.
SETUP_CYC, 1, clocks address/AEN are stable before the strobe asserts; >=1.
STROBE_CYC, 15, minimum clocks IOR_n/IOW_n held low (15 = 3 us at 5 MHz); >=1.
HOLD_CYC, 1, clocks address/write data held after strobe release; >=1.
TIMEOUT_CYC, 255, maximum extra clocks waiting for IOCHRDY; >=1.

Ports:
sys_clock  in  1  system clock (5 MHz).
reset  in  1  asynchronous, active-high reset.
req_valid  in  1  request present.
req_ready  out  1  engine can accept a request.
req_write  in  1  1 = I/O write, 0 = I/O read.
req_byte  in  1  1 = 8-bit transfer (D[7:0] only); forced 1 when DATA_W=8.
req_addr  in  ADDR_W  I/O port address.
req_wdata  in  DATA_W  write data.
rsp_valid  out  1  one-clock pulse, cycle complete.
rsp_rdata  out  DATA_W  read data (0 for writes).
rsp_timeout  out  1  qualifies rsp_valid: IOCHRDY timeout occurred.
isa_addr  out  ADDR_W  to A.
isa_data_out  out  DATA_W  to D when isa_data_oe=1.
isa_data_oe  out  1  D output enable.
isa_data_in  in  DATA_W  from D.
isa_iochrdy  in  1  card ready (0 = insert wait states); treated as synchronous.
isa_ior_n  out  1  I/O read strobe, active low.
isa_iow_n  out  1  I/O write strobe, active low.
isa_aen  out  1  address enable; 1 = slot must not decode.

Behaviour:
- Reset values: req_ready=0 during reset and 1 on the first clock after release. rsp_valid=0, rsp_rdata=0, rsp_timeout=0, isa_addr=0, isa_data_out=0, isa_data_oe=0, isa_ior_n=1, isa_iow_n=1, isa_aen=1, FSM=IDLE.
- Reset mid-cycle: strobes return high and oe drops to 0 asynchronously. No response is issued for the aborted request.
- IOR_n and IOW_n are never low in the same clock. isa_data_oe=1 only for writes, from SETUP entry through the end of HOLD.
- FSM states: IDLE, SETUP, STROBE, WAIT_RDY, HOLD, RESP.
- IDLE: req_ready=1. On req_valid, latch addr/wdata/write/byte and go to SETUP. Fields are captured here, so later changes to req_* have no effect.
- SETUP (SETUP_CYC clocks): isa_aen=0, isa_addr driven, write data driven; then go to STROBE.
- STROBE (STROBE_CYC clocks): the selected strobe is low. On the last clock, if isa_iochrdy=1 go to HOLD, else go to WAIT_RDY.
- WAIT_RDY: strobe stays low. The timer counts clocks while isa_iochrdy=0.
  - The first clock that samples isa_iochrdy=1 goes to HOLD.
  - When the count reaches TIMEOUT_CYC, set the timeout flag and go to HOLD.
- Read data: sampled from isa_data_in on the final strobe-low clock. Byte reads zero-extend D[7:0]. Byte writes drive the upper byte as 0.
- HOLD (HOLD_CYC clocks): strobe high, address/data/aen held; then go to RESP.
- RESP (1 clock): rsp_valid=1 with rsp_rdata/rsp_timeout valid, isa_aen returns to 1, oe=0; then go to IDLE.
  - rsp_rdata and rsp_timeout hold their values until the next RESP.
- Back-to-back: minimum request-to-request period is SETUP_CYC+STROBE_CYC+HOLD_CYC+2 clocks. There is no response backpressure.
- Counter: one shared down-counter, width clog2(max(SETUP_CYC,STROBE_CYC,HOLD_CYC,TIMEOUT_CYC)+1), reloaded on every state entry. No wrap: the counter saturates at 0.

Decomposition:
- Package isa_bus_pkg holds:
  - the FSM state enum;
  - ISA_IDLE_AEN / strobe-inactive constants;
  - a clog2-based counter-width function.
- Sub-module isa_cycle_timer: loadable down-counter with a done flag. It replaces the ad-hoc 4-bit 3 us counter. Everything else stays in one module.

Test Plan:
- 16-bit write: addr 0x0220, data 0xA55A, defaults, iochrdy=1 → aen low 1 clock before iow_n, iow_n low exactly 15 clocks, D=0xA55A throughout, ior_n stays 1, rsp_valid 1 clock after 1 hold clock, rsp_timeout=0.
- Byte read: addr 0x0388, isa_data_in=0x12F7 → ior_n low 15 clocks, oe=0 throughout, rsp_rdata=0x00F7.
- Wait states: iochrdy=0 for 7 clocks after strobe end → strobe low exactly 22 clocks, read data captured at last low clock, rsp_timeout=0.
- Timeout: iochrdy held 0 → strobe low 15+255 clocks, rsp_valid with rsp_timeout=1, then req_ready=1.
- Reset asserted mid-STROBE of a write → ior_n/iow_n=1, oe=0, aen=1 with no clock edge, no rsp_valid, next request runs normally.
- Back-to-back: req_valid held high for two requests → req_ready low between them, second SETUP starts exactly 19 clocks after the first.
